// File: rtl/io_arb_pkg.sv
// Shared types and constants for the two-requester IO arbiter.
package io_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [7:0] CONSDEV_ID = 8'd1;
    localparam logic [7:0] PROM_ID    = 8'd2;

    // Wide enough for READ_WAIT-1 with READ_WAIT up to 15.
    localparam int CNT_W = 4;

endpackage

// File: rtl/io_arb_rr.sv
// Two-way round-robin picker: the requester that did not win last time wins a tie.
module io_arb_rr (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic       grant_valid,
    output logic       grant_idx
);

    always_comb begin
        grant_valid = |valid;
        grant_idx   = 1'b0;
        if (valid == 2'b11) begin
            grant_idx = ~last_grant;
        end else begin
            grant_idx = valid[1];
        end
    end

endmodule

// File: rtl/io_arbiter.sv
// Arbitrates two command requesters onto a single IO device bank port.
// Handshake: a command is taken on a posedge where reqN_valid and reqN_ready are both high.
module io_arbiter
    import io_arb_pkg::*;
#(
    parameter int READ_WAIT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic        req0_write,
    input  logic [7:0]  req0_dev,
    input  logic [31:0] req0_wdata,
    output logic        req0_ready,
    output logic        req0_done,
    output logic [31:0] req0_rdata,
    input  logic        req1_valid,
    input  logic        req1_write,
    input  logic [7:0]  req1_dev,
    input  logic [31:0] req1_wdata,
    output logic        req1_ready,
    output logic        req1_done,
    output logic [31:0] req1_rdata,
    output logic [7:0]  io_device_id,
    output logic [31:0] io_value_in,
    output logic        io_is_write,
    input  logic [31:0] io_value_out,
    output logic        busy,
    output logic        owner
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_WAIT - 1);

    state_t           state, next_state;
    logic [CNT_W-1:0] cnt;
    logic             last_grant;
    logic             write_q;
    logic [7:0]       dev_q;
    logic [31:0]      wdata_q;
    logic             grant_valid;
    logic             grant_idx;
    logic             accept;
    logic             read_last;

    io_arb_rr u_rr (
        .valid       ({req1_valid, req0_valid}),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    assign accept    = (state == ST_IDLE) && grant_valid;
    assign read_last = (state == ST_XFER) && !write_q && (cnt == '0);

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (accept) next_state = ST_XFER;
            ST_XFER: if (write_q || cnt == '0) next_state = ST_RESP;
            ST_RESP: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            write_q    <= 1'b0;
            dev_q      <= '0;
            wdata_q    <= '0;
            req0_rdata <= '0;
            req1_rdata <= '0;
        end else begin
            if (accept) begin
                last_grant <= grant_idx;
                owner      <= grant_idx;
                write_q    <= grant_idx ? req1_write : req0_write;
                dev_q      <= grant_idx ? req1_dev : req0_dev;
                wdata_q    <= grant_idx ? req1_wdata : req0_wdata;
                cnt        <= CNT_LOAD;
            end else if (state == ST_XFER && !write_q && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (read_last) begin
                if (owner) req1_rdata <= io_value_out;
                else       req0_rdata <= io_value_out;
            end
        end
    end

    // Ready goes only to the round-robin winner, and only while idle.
    assign req0_ready   = accept && !grant_idx;
    assign req1_ready   = accept && grant_idx;
    assign req0_done    = (state == ST_RESP) && !owner;
    assign req1_done    = (state == ST_RESP) && owner;
    assign io_device_id = dev_q;
    assign io_value_in  = wdata_q;
    assign io_is_write  = (state == ST_XFER) && write_q;
    assign busy         = (state != ST_IDLE);

endmodule

// File: tb/tb_io_arbiter.sv
// Directed and randomized bench for io_arbiter against a transaction-level model.
module tb_io_arbiter;

    localparam int RW = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req0_write, req1_valid, req1_write;
    logic [7:0]  req0_dev, req1_dev;
    logic [31:0] req0_wdata, req1_wdata;
    logic        req0_ready, req0_done, req1_ready, req1_done;
    logic [31:0] req0_rdata, req1_rdata;
    logic [7:0]  io_device_id;
    logic [31:0] io_value_in;
    logic        io_is_write;
    logic [31:0] io_value_out;
    logic        busy, owner;

    int n_tests = 0;
    int n_fail  = 0;

    // Device bank seen by the DUT; written only through io_is_write.
    logic [31:0] dev_bank [256];
    // Model: expected bank contents, last grant and per-requester read results.
    logic [31:0] mbank [256];
    logic        m_last;
    logic [31:0] m_rdata [2];
    logic [31:0] exp_q [$];

    io_arbiter #(.READ_WAIT(RW)) dut (
        .clk          (clk),
        .reset        (reset),
        .req0_valid   (req0_valid),
        .req0_write   (req0_write),
        .req0_dev     (req0_dev),
        .req0_wdata   (req0_wdata),
        .req0_ready   (req0_ready),
        .req0_done    (req0_done),
        .req0_rdata   (req0_rdata),
        .req1_valid   (req1_valid),
        .req1_write   (req1_write),
        .req1_dev     (req1_dev),
        .req1_wdata   (req1_wdata),
        .req1_ready   (req1_ready),
        .req1_done    (req1_done),
        .req1_rdata   (req1_rdata),
        .io_device_id (io_device_id),
        .io_value_in  (io_value_in),
        .io_is_write  (io_is_write),
        .io_value_out (io_value_out),
        .busy         (busy),
        .owner        (owner)
    );

    always #5 clk = ~clk;

    assign io_value_out = dev_bank[io_device_id];

    always @(negedge clk) begin
        if (io_is_write) dev_bank[io_device_id] <= io_value_in;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic scramble_cmd();
        req0_write = 1'($urandom_range(0, 1));
        req1_write = 1'($urandom_range(0, 1));
        req0_dev   = 8'($urandom);
        req1_dev   = 8'($urandom);
        req0_wdata = $urandom;
        req1_wdata = $urandom;
    endtask

    // Called just after a posedge with the DUT idle; returns just after a posedge, idle again.
    task automatic txn(input string tag,
                       input logic v0, input logic w0, input logic [7:0] d0, input logic [31:0] wd0,
                       input logic v1, input logic w1, input logic [7:0] d1, input logic [31:0] wd1);
        logic        win, w, seen;
        logic [7:0]  d;
        logic [31:0] wd, rd;
        int          lat, n_wr;
        req0_valid = v0; req0_write = w0; req0_dev = d0; req0_wdata = wd0;
        req1_valid = v1; req1_write = w1; req1_dev = d1; req1_wdata = wd1;
        @(negedge clk);
        win = (v0 && v1) ? ~m_last : v1;
        check({tag, ":ready0"}, 32'(req0_ready), 32'(!win));
        check({tag, ":ready1"}, 32'(req1_ready), 32'(win));
        w  = win ? w1 : w0;
        d  = win ? d1 : d0;
        wd = win ? wd1 : wd0;
        m_last = win;
        if (w) begin
            mbank[d] = wd;
        end else begin
            exp_q.push_back(mbank[d]);
            m_rdata[win] = mbank[d];
        end
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        scramble_cmd();
        check({tag, ":busy"}, 32'(busy), 32'd1);
        check({tag, ":owner"}, 32'(owner), 32'(win));
        seen = 1'b0;
        lat  = 0;
        n_wr = 0;
        for (int c = 1; c <= 40 && !seen; c++) begin
            @(negedge clk);
            if (io_is_write) begin
                n_wr++;
                check({tag, ":wr_dev"}, 32'(io_device_id), 32'(d));
                check({tag, ":wr_data"}, io_value_in, wd);
            end
            if (req0_ready || req1_ready) check({tag, ":ready_busy"}, 32'({req1_ready, req0_ready}), 32'd0);
            if (req0_done || req1_done) begin
                seen = 1'b1;
                lat  = c;
                check({tag, ":done_owner"}, 32'({req1_done, req0_done}), win ? 32'd2 : 32'd1);
            end
        end
        check({tag, ":done_seen"}, 32'(seen), 32'd1);
        check({tag, ":latency"}, 32'(lat), w ? 32'd2 : 32'(RW + 1));
        check({tag, ":wr_pulses"}, 32'(n_wr), w ? 32'd1 : 32'd0);
        if (!w) begin
            rd = exp_q.pop_front();
            check({tag, ":rdata_owner"}, win ? req1_rdata : req0_rdata, rd);
        end
        check({tag, ":rdata0"}, req0_rdata, m_rdata[0]);
        check({tag, ":rdata1"}, req1_rdata, m_rdata[1]);
        @(posedge clk);
        #1;
        check({tag, ":idle"}, 32'(busy), 32'd0);
        check({tag, ":dev_hold"}, 32'(io_device_id), 32'(d));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ":busy"}, 32'(busy), 32'd0);
        check({tag, ":owner"}, 32'(owner), 32'd0);
        check({tag, ":is_write"}, 32'(io_is_write), 32'd0);
        check({tag, ":dev"}, 32'(io_device_id), 32'd0);
        check({tag, ":value_in"}, io_value_in, 32'd0);
        check({tag, ":rdata0"}, req0_rdata, 32'd0);
        check({tag, ":rdata1"}, req1_rdata, 32'd0);
        check({tag, ":done"}, 32'({req1_done, req0_done}), 32'd0);
    endtask

    initial begin
        logic v0, v1;
        for (int i = 0; i < 256; i++) begin
            dev_bank[i] = 32'hA500_0000 ^ 32'(i);
            mbank[i]    = 32'hA500_0000 ^ 32'(i);
        end
        dev_bank[2] = 32'h1234;
        mbank[2]    = 32'h1234;
        m_last = 1'b1;
        m_rdata[0] = '0;
        m_rdata[1] = '0;
        reset = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        scramble_cmd();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");
        check("reset:ready", 32'({req1_ready, req0_ready}), 32'd0);
        @(posedge clk);
        #1;

        // Case 1: write to the console device.
        txn("c1", 1'b1, 1'b1, 8'd1, 32'hDEADBEEF, 1'b0, 1'b0, 8'd0, 32'd0);
        check("c1:bank1", dev_bank[1], 32'hDEADBEEF);

        // Case 2: read of device 2 by requester 1.
        txn("c2", 1'b0, 1'b0, 8'd0, 32'd0, 1'b1, 1'b0, 8'd2, 32'd0);
        check("c2:rdata1", req1_rdata, 32'h1234);

        // Case 3: both requesters contend; grants alternate after a fresh reset below too.
        for (int i = 0; i < 4; i++) begin
            txn("c3", 1'b1, 1'(i[0]), 8'(i + 4), $urandom, 1'b1, 1'(~i[0]), 8'(i + 8), $urandom);
        end

        // Case 4: reset lands while a write is in XFER.
        req0_valid = 1'b1; req0_write = 1'b1; req0_dev = 8'd3; req0_wdata = 32'hCAFE_0003;
        req1_valid = 1'b0;
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("c4:xfer_write", 32'(io_is_write), 32'd1);
        mbank[3] = 32'hCAFE_0003;
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_last = 1'b1;
        m_rdata[0] = '0;
        m_rdata[1] = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_reset_outputs("c4");
        end
        @(posedge clk);
        #1;
        check("c4:bank3", dev_bank[3], 32'hCAFE_0003);

        // Alternation from reset: req0 first.
        for (int i = 0; i < 4; i++) begin
            txn("c3b", 1'b1, 1'b0, 8'd3, 32'd0, 1'b1, 1'b0, 8'd2, 32'd0);
        end

        // Case 5: inputs scrambled after accept are ignored (done inside txn).
        txn("c5", 1'b1, 1'b1, 8'd9, 32'h0BAD_F00D, 1'b0, 1'b0, 8'd0, 32'd0);
        check("c5:bank9", dev_bank[9], 32'h0BAD_F00D);

        // Case 6: read, write, read on device 1.
        txn("c6a", 1'b1, 1'b0, 8'd1, 32'd0, 1'b0, 1'b0, 8'd0, 32'd0);
        check("c6a:old", req0_rdata, 32'hDEADBEEF);
        txn("c6b", 1'b1, 1'b1, 8'd1, 32'h5, 1'b0, 1'b0, 8'd0, 32'd0);
        check("c6b:kept", req0_rdata, 32'hDEADBEEF);
        txn("c6c", 1'b1, 1'b0, 8'd1, 32'd0, 1'b0, 1'b0, 8'd0, 32'd0);
        check("c6c:new", req0_rdata, 32'h5);

        // Randomized traffic over a small device range to force reuse.
        for (int i = 0; i < 40; i++) begin
            v0 = 1'($urandom_range(0, 1));
            v1 = 1'($urandom_range(0, 1));
            if (!v0 && !v1) v0 = 1'b1;
            txn("rnd", v0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), $urandom,
                v1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/io_arbiter.md
IO_ARBITER -- requirements
Module: io_arbiter

Interface
REQ-001 SHALL have parameter READ_WAIT, default 1, which sets the number of cycles the device ID is held before read data is captured; legal range 1..15.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on posedge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have ports reqN_valid, input, 1 bit (N=0,1): requester N has a command pending.
REQ-005 SHALL have ports reqN_write, input, 1 bit: 1=write, 0=read.
REQ-006 SHALL have ports reqN_dev, input, 8 bits: target device ID.
REQ-007 SHALL have ports reqN_wdata, input, 32 bits: write data.
REQ-008 SHALL have ports reqN_ready, output, 1 bit: command accepted this cycle.
REQ-009 SHALL have ports reqN_done, output, 1 bit: one-cycle completion pulse.
REQ-010 SHALL have ports reqN_rdata, output, 32 bits: read result for requester N.
REQ-011 SHALL have port io_device_id, output, 8 bits: device select to the IO device bank.
REQ-012 SHALL have port io_value_in, output, 32 bits: write data to the IO device bank.
REQ-013 SHALL have port io_is_write, output, 1 bit: write strobe; the device bank commits it on the following negedge.
REQ-014 SHALL have port io_value_out, input, 32 bits: read data from the IO device bank.
REQ-015 SHALL have port busy, output, 1 bit: state is not IDLE.
REQ-016 SHALL have port owner, output, 1 bit: index of the requester currently or most recently granted.

Function
REQ-017 SHALL implement the states IDLE, XFER and RESP.
REQ-018 In IDLE, reqN_ready SHALL be asserted combinationally for exactly one valid requester (the winner); a transfer is accepted when valid and ready are both high at posedge.
REQ-019 Arbitration SHALL be round-robin: with both requesters valid, the requester not equal to last_grant wins; with one valid, that one wins.
REQ-020 On accept, the block SHALL latch dev, write and wdata, set owner and last_grant to the winner, and go to XFER.
REQ-021 In XFER for a write, io_is_write SHALL be 1 for exactly one cycle, then the block goes to RESP.
REQ-022 In XFER for a read, the block SHALL hold io_device_id for READ_WAIT cycles using a down-counter; on the final edge it captures io_value_out into reqN_rdata of the owner and goes to RESP.
REQ-023 In RESP, the owner's reqN_done SHALL be 1 for one cycle; the next state is always IDLE.
REQ-024 Latency from the accept edge to done high SHALL be 2 cycles for a write and READ_WAIT+1 cycles for a read; minimum spacing between back-to-back accepts is 3 cycles for writes.
REQ-025 io_device_id and io_value_in SHALL hold the latched values from XFER until the next accept (no glitch in IDLE).
REQ-026 io_is_write SHALL be 0 in all states other than XFER for a write.
REQ-027 reqN_rdata SHALL hold its value until the next read completion for requester N; a write SHALL NOT modify it.
REQ-028 Changes to reqN_valid or the command inputs after accept SHALL be ignored until the next IDLE.
REQ-029 No ready SHALL be asserted outside IDLE, and done SHALL never be asserted to the non-owner.

Reset
REQ-030 reset SHALL take priority over all other inputs; it forces state=IDLE, the counter to 0, last_grant=1 (so req0 wins first), and owner=0.
REQ-031 After reset, io_device_id, io_value_in and both reqN_rdata SHALL be 0, and io_is_write, ready, done and busy SHALL be 0.
REQ-032 Reset during XFER or RESP SHALL abort the transfer with no done pulse and no further io_is_write.

Structure
REQ-033 The shared package io_arb_pkg SHALL hold the state enum, CONSDEV_ID=8'd1, PROM_ID=8'd2, and the READ_WAIT counter width.
REQ-034 The two-way round-robin picker SHALL be the sub-module io_arb_rr (inputs: valid[1:0], last_grant; outputs: grant_valid, grant_idx).

Verification
REQ-035 Case 1: req0 writes dev 1, wdata 32'hDEADBEEF -> io_is_write is high for one cycle with io_device_id=1; req0_done fires 2 cycles after accept; the device bank entry[1] reads back DEADBEEF.
REQ-036 Case 2: req1 reads dev 2 with READ_WAIT=3 while io_value_out=32'h1234 -> req1_done fires 4 cycles after accept; req1_rdata=32'h1234; req0_rdata stays unchanged.
REQ-037 Case 3: both requesters valid continuously after reset -> grants alternate 0,1,0,1, and each done pulses only to its owner.
REQ-038 Case 4: reset asserted in the XFER cycle of a write -> no done pulse; next cycle state is IDLE and all outputs are 0.
REQ-039 Case 5: req0 drops valid and changes dev after accept -> the transfer completes with the original dev and data.
REQ-040 Case 6: read dev 1, then write dev 1 with 32'h5, then read dev 1 -> reqN_rdata sequence is old value, then 32'h5.
